// File: rtl/sha2_compress_iter_pkg.sv
// Shared SHA-2 constants, FSM state type and the four sigma functions
// for the 32-bit (SHA-256) and 64-bit (SHA-512) word sizes.
package sha2_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int ROT_BS0_32 [0:2] = '{2, 13, 22};
    localparam int ROT_BS1_32 [0:2] = '{6, 11, 25};
    localparam int ROT_SS0_32 [0:2] = '{7, 18, 3};
    localparam int ROT_SS1_32 [0:2] = '{17, 19, 10};
    localparam int ROT_BS0_64 [0:2] = '{28, 34, 39};
    localparam int ROT_BS1_64 [0:2] = '{14, 18, 41};
    localparam int ROT_SS0_64 [0:2] = '{1, 8, 7};
    localparam int ROT_SS1_64 [0:2] = '{19, 61, 6};

    localparam logic [31:0] K256 [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] big_sigma0_32(input logic [31:0] x);
        return rotr32(x, ROT_BS0_32[0]) ^ rotr32(x, ROT_BS0_32[1]) ^ rotr32(x, ROT_BS0_32[2]);
    endfunction

    function automatic logic [31:0] big_sigma1_32(input logic [31:0] x);
        return rotr32(x, ROT_BS1_32[0]) ^ rotr32(x, ROT_BS1_32[1]) ^ rotr32(x, ROT_BS1_32[2]);
    endfunction

    // The third entry of each small-sigma table is a logical shift, not a rotation.
    function automatic logic [31:0] small_sigma0_32(input logic [31:0] x);
        return rotr32(x, ROT_SS0_32[0]) ^ rotr32(x, ROT_SS0_32[1]) ^ (x >> ROT_SS0_32[2]);
    endfunction

    function automatic logic [31:0] small_sigma1_32(input logic [31:0] x);
        return rotr32(x, ROT_SS1_32[0]) ^ rotr32(x, ROT_SS1_32[1]) ^ (x >> ROT_SS1_32[2]);
    endfunction

    function automatic logic [63:0] big_sigma0_64(input logic [63:0] x);
        return rotr64(x, ROT_BS0_64[0]) ^ rotr64(x, ROT_BS0_64[1]) ^ rotr64(x, ROT_BS0_64[2]);
    endfunction

    function automatic logic [63:0] big_sigma1_64(input logic [63:0] x);
        return rotr64(x, ROT_BS1_64[0]) ^ rotr64(x, ROT_BS1_64[1]) ^ rotr64(x, ROT_BS1_64[2]);
    endfunction

    function automatic logic [63:0] small_sigma0_64(input logic [63:0] x);
        return rotr64(x, ROT_SS0_64[0]) ^ rotr64(x, ROT_SS0_64[1]) ^ (x >> ROT_SS0_64[2]);
    endfunction

    function automatic logic [63:0] small_sigma1_64(input logic [63:0] x);
        return rotr64(x, ROT_SS1_64[0]) ^ rotr64(x, ROT_SS1_64[1]) ^ (x >> ROT_SS1_64[2]);
    endfunction

endpackage

// File: rtl/sha2_compress_iter_if.sv
// Block-in / state-out bundle of the SHA-2 compression engine.
// Handshake: a transfer happens on a rising clk edge where valid && ready; the
// source holds valid and its data stable until then, and ready may depend on
// the peer's ready but never on the peer's valid.
interface sha2_compress_iter_if #(parameter int DATA_WIDTH = 32);
    logic                     in_valid;
    logic                     in_ready;
    logic [8*DATA_WIDTH-1:0]  h_in;
    logic [16*DATA_WIDTH-1:0] blk_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [8*DATA_WIDTH-1:0]  h_out;
    logic                     busy;

    modport master (
        output in_valid, h_in, blk_in, out_ready,
        input  in_ready, out_valid, h_out, busy
    );

    modport slave (
        input  in_valid, h_in, blk_in, out_ready,
        output in_ready, out_valid, h_out, busy
    );
endinterface

// File: rtl/sha2_compress_iter_round.sv
// One combinational SHA-2 round: A..H, W[t], K[t] in, next A..H out.
// Index 7 of the packed state is A, index 0 is H (same order as h_in).
module sha2_round
    import sha2_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [7:0][DATA_WIDTH-1:0] st_in,
    input  logic [DATA_WIDTH-1:0]      w,
    input  logic [DATA_WIDTH-1:0]      k,
    output logic [7:0][DATA_WIDTH-1:0] st_out
);
    logic [DATA_WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [DATA_WIDTH-1:0] bs0, bs1, ch, maj, t1, t2, a_new, e_new;

    assign {a, b, c, d, e, f, g, h} = st_in;

    if (DATA_WIDTH == 32) begin : g_w32
        assign bs0 = big_sigma0_32(a);
        assign bs1 = big_sigma1_32(e);
    end else begin : g_w64
        assign bs0 = big_sigma0_64(a);
        assign bs1 = big_sigma1_64(e);
    end

    assign ch    = (e & f) ^ (~e & g);
    assign maj   = (a & b) ^ (a & c) ^ (b & c);
    assign t1    = h + bs1 + ch + k + w;
    assign t2    = bs0 + maj;
    assign a_new = t1 + t2;
    assign e_new = d + t1;

    assign st_out = {a_new, a, b, c, e_new, e, f, g};
endmodule

// File: rtl/sha2_compress_iter.sv
// Iterative SHA-2 compression, one round per clock (SHA-256 or SHA-512).
// Define SHA2_FEEDFWD_EN to add the saved chaining value into h_out (digest mode).
module sha2_compress_iter
    import sha2_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    sha2_compress_iter_if.slave bus
);
    localparam int DW     = DATA_WIDTH;
    localparam int ROUNDS = (DATA_WIDTH == 64) ? 80 : 64;

    if (DW != 32 && DW != 64) begin : g_bad_width
        $error("sha2_compress_iter: DATA_WIDTH must be 32 or 64");
    end

    state_e               state_q, state_d;
    logic [6:0]           cnt_q;
    logic [7:0][DW-1:0]   work_q, work_nxt, result;
    logic [15:0][DW-1:0]  win_q;
    logic [DW-1:0]        kt, ss0, ss1, w_new;
    logic [8*DW-1:0]      h_out_q;
    logic                 load, step, finish;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == 7'(ROUNDS - 1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    load    = bus.in_valid;
                    state_d = bus.in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Window head (index 15) is W[t]; the tail refills from the recurrence.
    if (DW == 32) begin : g_sched32
        assign kt  = K256[cnt_q[5:0]];
        assign ss0 = small_sigma0_32(win_q[14]);
        assign ss1 = small_sigma1_32(win_q[1]);
    end else begin : g_sched64
        assign kt  = K512[cnt_q];
        assign ss0 = small_sigma0_64(win_q[14]);
        assign ss1 = small_sigma1_64(win_q[1]);
    end
    assign w_new = ss1 + win_q[6] + ss0 + win_q[15];

    sha2_round #(.DATA_WIDTH(DW)) u_round (
        .st_in  (work_q),
        .w      (win_q[15]),
        .k      (kt),
        .st_out (work_nxt)
    );

`ifdef SHA2_FEEDFWD_EN
    logic [7:0][DW-1:0] saved_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    saved_q <= '0;
        else if (load) saved_q <= bus.h_in;
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < 8; i++) result[i] = saved_q[i] + work_nxt[i];
    end
`else
    assign result = work_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            h_out_q <= '0;
        end else begin
            if (load) begin
                work_q <= bus.h_in;
                win_q  <= bus.blk_in;
                cnt_q  <= '0;
            end else if (step) begin
                work_q <= work_nxt;
                win_q  <= {win_q[14:0], w_new};
                cnt_q  <= cnt_q + 7'd1;
            end
            if (finish) h_out_q <= result;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.h_out     = h_out_q;
endmodule

// File: tb/tb_sha2_compress_iter.sv
// Directed bench for sha2_compress_iter: SHA-256 and SHA-512 "abc" vectors,
// backpressure, back-to-back blocks and reset in mid-run.
module tb_sha2_compress_iter;
    localparam logic [255:0] IV256  = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] DIG256 = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                       32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [511:0] ABC256 = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] IV512  = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
                                       64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                       64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                                       64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [511:0] DIG512 = {64'hddaf35a193617aba, 64'hcc417349ae204131,
                                       64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
                                       64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                                       64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
    localparam logic [1023:0] ABC512 = {64'h6162638000000000, 896'h0, 64'h18};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc;
    logic [255:0] exp256;
    logic [511:0] exp512;

    always #5 clk = ~clk;

    sha2_compress_iter_if #(.DATA_WIDTH(32)) if256 ();
    sha2_compress_iter_if #(.DATA_WIDTH(64)) if512 ();

    sha2_compress_iter #(.DATA_WIDTH(32)) u_dut256 (.clk(clk), .rst_n(rst_n), .bus(if256));
    sha2_compress_iter #(.DATA_WIDTH(64)) u_dut512 (.clk(clk), .rst_n(rst_n), .bus(if512));

    function automatic logic [255:0] sub256(input logic [255:0] d, input logic [255:0] iv);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = d[i*32 +: 32] - iv[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [511:0] sub512(input logic [511:0] d, input logic [511:0] iv);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = d[i*64 +: 64] - iv[i*64 +: 64];
        return r;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one block, leaves the bench at cycle 1.
    task automatic start256(input logic [255:0] h, input logic [511:0] b);
        if256.in_valid = 1'b1;
        if256.h_in     = h;
        if256.blk_in   = b;
        check("in_ready_at_accept256", 512'(if256.in_ready), 512'(1'b1));
        @(negedge clk);
        if256.in_valid = 1'b0;
        check("busy_cycle1_256", 512'(if256.busy), 512'(1'b1));
    endtask

    task automatic wait_out256(output int c);
        c = 1;
        while (if256.out_valid !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait_out512(output int c);
        c = 1;
        while (if512.out_valid !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SHA2_FEEDFWD_EN
        exp256 = DIG256;
        exp512 = DIG512;
`else
        exp256 = sub256(DIG256, IV256);
        exp512 = sub512(DIG512, IV512);
`endif
        if256.in_valid = 1'b0; if256.out_ready = 1'b0; if256.h_in = '0; if256.blk_in = '0;
        if512.in_valid = 1'b0; if512.out_ready = 1'b0; if512.h_in = '0; if512.blk_in = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 512'(if256.out_valid), 512'(1'b0));
        check("rst_busy", 512'(if256.busy), 512'(1'b0));
        check("rst_in_ready", 512'(if256.in_ready), 512'(1'b1));
        check("rst_h_out256", 512'(if256.h_out), 512'(0));
        check("rst_h_out512", if512.h_out, 512'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // SHA-256 "abc", latency and result, consumer stalled
        start256(IV256, ABC256);
        wait_out256(cyc);
        check("latency256", 512'(cyc), 512'(65));
        check("digest256", 512'(if256.h_out), 512'(exp256));
`ifndef SHA2_FEEDFWD_EN
        check("raw_word_a256", 512'(if256.h_out[255:224]), 512'(32'h506e3058));
`endif
        check("done_busy256", 512'(if256.busy), 512'(1'b0));

        // Backpressure: hold 10 cycles, in_valid pulses must be ignored
        for (int i = 0; i < 10; i++) begin
            if256.in_valid = i[0];
            if256.h_in     = {8{32'hdeadbeef}};
            if256.blk_in   = {16{32'h0badf00d}};
            check("hold_out_valid", 512'(if256.out_valid), 512'(1'b1));
            check("hold_h_out", 512'(if256.h_out), 512'(exp256));
            check("hold_in_ready", 512'(if256.in_ready), 512'(1'b0));
            @(negedge clk);
        end
        if256.in_valid  = 1'b0;
        check("hold_end_out_valid", 512'(if256.out_valid), 512'(1'b1));
        if256.out_ready = 1'b1;
        #1;
        check("in_ready_follows_out_ready", 512'(if256.in_ready), 512'(1'b1));
        @(negedge clk);
        check("idle_out_valid", 512'(if256.out_valid), 512'(1'b0));
        check("idle_in_ready", 512'(if256.in_ready), 512'(1'b1));

        // Back-to-back: second block offered in the DONE cycle
        start256(IV256, ABC256);
        wait_out256(cyc);
        check("b2b_latency1", 512'(cyc), 512'(65));
        check("b2b_digest1", 512'(if256.h_out), 512'(exp256));
        start256(IV256, ABC256);
        check("b2b_out_valid_drop", 512'(if256.out_valid), 512'(1'b0));
        wait_out256(cyc);
        check("b2b_latency2", 512'(cyc), 512'(65));
        check("b2b_digest2", 512'(if256.h_out), 512'(exp256));
        @(negedge clk);
        check("b2b_back_idle", 512'(if256.out_valid), 512'(1'b0));

        // SHA-512 "abc"
        if512.out_ready = 1'b1;
        if512.in_valid  = 1'b1;
        if512.h_in      = IV512;
        if512.blk_in    = ABC512;
        check("in_ready_at_accept512", 512'(if512.in_ready), 512'(1'b1));
        @(negedge clk);
        if512.in_valid = 1'b0;
        check("busy_cycle1_512", 512'(if512.busy), 512'(1'b1));
        wait_out512(cyc);
        check("latency512", 512'(cyc), 512'(81));
        check("digest512", if512.h_out, exp512);
        @(negedge clk);

        // Reset during round 30, then a clean block
        start256(IV256, ABC256);
        repeat (30) @(negedge clk);
        check("busy_before_reset", 512'(if256.busy), 512'(1'b1));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 512'(if256.out_valid), 512'(1'b0));
        check("midrst_busy", 512'(if256.busy), 512'(1'b0));
        check("midrst_in_ready", 512'(if256.in_ready), 512'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start256(IV256, ABC256);
        wait_out256(cyc);
        check("post_rst_latency", 512'(cyc), 512'(65));
        check("post_rst_digest", 512'(if256.h_out), 512'(exp256));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
